// File: rtl/alarm_controller.sv
// alarm_controller: anti-theft FSM that drives the countdown timer handshake, the siren and the status LED.
// Define ALARM_FUEL_PUMP_EN to add the hidden_sw/brake fuel-pump interlock.
module alarm_controller #(
  parameter logic [3:0] DEF_ARM = 4'd6,
  parameter logic [3:0] DEF_DRIVER = 4'd8,
  parameter logic [3:0] DEF_PASS = 4'd15,
  parameter logic [3:0] DEF_ALARM = 4'd10
) (
  input logic clock,
  input logic reset,
  input logic ignition,
  input logic door_driver,
  input logic door_pass,
  input logic reprogram,
  input logic [1:0] time_param_sel,
  input logic [3:0] time_value,
  input logic expired,
  input logic one_hz_enable,
  input logic half_hz_enable,
`ifdef ALARM_FUEL_PUMP_EN
  input logic hidden_sw,
  input logic brake,
  output logic fuel_pump,
`endif
  output logic start_timer,
  output logic [3:0] value,
  output logic siren,
  output logic status,
  output logic [2:0] state_display
);
  typedef enum logic [2:0] {
    ARMED, TRIGGERED, ALARM, ALARM_HOLD, DISARMED, WAIT_OPEN, WAIT_CLOSE, ARMING
  } state_t;
  state_t state, nxt;
  logic [3:0] prm [4];
  logic win, go, open, exp_ok;
  logic [3:0] go_val;
  logic unused_half;
  assign unused_half = half_hz_enable;
  assign open = door_driver | door_pass;
  // expired is only trusted once the start window has closed
  assign exp_ok = expired & ~start_timer;
  always_comb begin
    nxt = state;
    go = 1'b0;
    go_val = value;
    if (reprogram) nxt = ARMED;
    else if (ignition) nxt = DISARMED;
    else
      case (state)
        ARMED: if (open) begin
          nxt = TRIGGERED;
          go = 1'b1;
          go_val = door_driver ? prm[1] : prm[2];
        end
        TRIGGERED: nxt = exp_ok ? ALARM : TRIGGERED;
        ALARM: if (!open) begin
          nxt = ALARM_HOLD;
          go = 1'b1;
          go_val = prm[3];
        end
        ALARM_HOLD: nxt = open ? ALARM : exp_ok ? ARMED : ALARM_HOLD;
        DISARMED: nxt = WAIT_OPEN;
        WAIT_OPEN: nxt = door_driver ? WAIT_CLOSE : WAIT_OPEN;
        WAIT_CLOSE: if (!open) begin
          nxt = ARMING;
          go = 1'b1;
          go_val = prm[0];
        end
        ARMING: nxt = open ? WAIT_CLOSE : exp_ok ? ARMED : ARMING;
        default: nxt = ARMED;
      endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ARMED;
      win <= 1'b0;
      start_timer <= 1'b0;
      value <= 4'd0;
      siren <= 1'b0;
      status <= 1'b0;
      state_display <= 3'd0;
      prm[0] <= DEF_ARM;
      prm[1] <= DEF_DRIVER;
      prm[2] <= DEF_PASS;
      prm[3] <= DEF_ALARM;
    end else begin
      state <= nxt;
      state_display <= nxt;
      siren <= nxt == ALARM || nxt == ALARM_HOLD;
      status <= nxt == ARMED ? one_hz_enable : nxt inside {TRIGGERED, ALARM, ALARM_HOLD};
      // win marks that one more window cycle is owed after the current one
      if (reprogram) begin
        prm[time_param_sel] <= time_value;
        start_timer <= 1'b0;
        win <= 1'b0;
      end else if (go) begin
        start_timer <= 1'b1;
        win <= 1'b1;
        value <= go_val;
      end else begin
        start_timer <= win;
        win <= 1'b0;
      end
    end
  end
`ifdef ALARM_FUEL_PUMP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fuel_pump <= 1'b0;
    else if (!ignition) fuel_pump <= 1'b0;
    else if (hidden_sw && brake) fuel_pump <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed-vector bench for alarm_controller with hand-computed expectations.
module tb_alarm_controller;
  logic clock = 1'b0, reset = 1'b0;
  logic ignition = 0, door_driver = 0, door_pass = 0, reprogram = 0;
  logic [1:0] time_param_sel = 0;
  logic [3:0] time_value = 0;
  logic expired = 0, one_hz_enable = 0, half_hz_enable = 0;
  logic start_timer, siren, status;
  logic [3:0] value;
  logic [2:0] state_display;
  int total = 0, bad = 0;
`ifdef ALARM_FUEL_PUMP_EN
  logic hidden_sw = 0, brake = 0, fuel_pump;
`endif
  alarm_controller dut (
    .clock(clock), .reset(reset), .ignition(ignition), .door_driver(door_driver),
    .door_pass(door_pass), .reprogram(reprogram), .time_param_sel(time_param_sel),
    .time_value(time_value), .expired(expired), .one_hz_enable(one_hz_enable),
    .half_hz_enable(half_hz_enable),
`ifdef ALARM_FUEL_PUMP_EN
    .hidden_sw(hidden_sw), .brake(brake), .fuel_pump(fuel_pump),
`endif
    .start_timer(start_timer), .value(value), .siren(siren), .status(status),
    .state_display(state_display)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    #22;
    check("rst_start", start_timer, 0);
    check("rst_value", value, 0);
    check("rst_siren", siren, 0);
    check("rst_status", status, 0);
    check("rst_state", state_display, 0);
    reset = 1;
    door_driver = 1; step();
    check("drv_state", state_display, 1);
    check("drv_start1", start_timer, 1);
    check("drv_value", value, 8);
    check("drv_status", status, 1);
    step(); check("drv_start2", start_timer, 1);
    step(); check("drv_start_end", start_timer, 0);
    expired = 1; step(); expired = 0;
    check("alarm_state", state_display, 2);
    check("alarm_siren", siren, 1);
    door_driver = 0; step();
    check("hold_state", state_display, 3);
    check("hold_start", start_timer, 1);
    check("hold_value", value, 10);
    door_pass = 1; step();
    check("reopen_state", state_display, 2);
    check("reopen_siren", siren, 1);
    check("reopen_start2", start_timer, 1);
    door_pass = 0; step();
    check("rehold_state", state_display, 3);
    check("rehold_start1", start_timer, 1);
    step(); check("restart_start2", start_timer, 1);
    step(); check("restart_end", start_timer, 0);
    expired = 1; step(); expired = 0;
    check("hold_exp_state", state_display, 0);
    check("hold_exp_siren", siren, 0);
    ignition = 1; step();
    check("dis_state", state_display, 4);
    check("dis_status", status, 0);
    ignition = 0; step(); check("wopen_state", state_display, 5);
    door_driver = 1; step(); check("wclose_state", state_display, 6);
    door_driver = 0; step();
    check("arming_state", state_display, 7);
    check("arming_start", start_timer, 1);
    check("arming_value", value, 6);
    step(); step(); check("arming_end", start_timer, 0);
    one_hz_enable = 1; expired = 1; step(); expired = 0;
    check("armed_state", state_display, 0);
    check("armed_status_hi", status, 1);
    one_hz_enable = 0; step(); check("armed_status_lo", status, 0);
    ignition = 1; step(); check("dis2_state", state_display, 4);
    reprogram = 1; time_param_sel = 2; time_value = 3; step(); reprogram = 0;
    check("reprog_state", state_display, 0);
    ignition = 0; door_pass = 1; step();
    check("pass_state", state_display, 1);
    check("pass_value", value, 3);
    check("pass_start1", start_timer, 1);
    expired = 1; step(); expired = 0;
    check("stale_state", state_display, 1);
    check("stale_start2", start_timer, 1);
    step();
    check("stale_end", start_timer, 0);
    check("stale_end_state", state_display, 1);
    expired = 1; step(); expired = 0;
    check("post_exp_state", state_display, 2);
    door_pass = 0; step(); check("hold2_start", start_timer, 1);
    reprogram = 1; time_param_sel = 1; time_value = 0; step(); reprogram = 0;
    check("cancel_start", start_timer, 0);
    check("cancel_state", state_display, 0);
    check("cancel_siren", siren, 0);
    door_driver = 1; step();
    check("zero_value", value, 0);
    check("zero_start", start_timer, 1);
    step(); step();
    expired = 1; step(); expired = 0;
    check("zero_alarm", state_display, 2);
    door_driver = 0; step();
    check("pre_rst_start", start_timer, 1);
    #3 reset = 0; #1;
    check("arst_start", start_timer, 0);
    check("arst_siren", siren, 0);
    check("arst_state", state_display, 0);
    check("arst_value", value, 0);
    check("arst_status", status, 0);
    reset = 1; door_driver = 1; step();
    check("default_value", value, 8);
    check("default_state", state_display, 1);
    door_driver = 0;
`ifdef ALARM_FUEL_PUMP_EN
    ignition = 1; hidden_sw = 1; brake = 1; step();
    check("fuel_set", fuel_pump, 1);
    hidden_sw = 0; brake = 0; step(); check("fuel_hold", fuel_pump, 1);
    ignition = 0; step(); check("fuel_clear", fuel_pump, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_controller.md
# alarm_controller

Anti-theft supervisor for the car-alarm design and the initiating side of the countdown timer handshake. It watches ignition and door inputs, selects the programmed delay for each situation, and drives `start_timer`/`value` into the timer. It consumes `expired`, `one_hz_enable` and `half_hz_enable` from the timer and drives the siren and status LED.

## Interface
- `DEF_ARM`, 6: reset value of the arm-delay parameter, in seconds.
- `DEF_DRIVER`, 8: reset value of the driver-door delay.
- `DEF_PASS`, 15: reset value of the passenger-door delay.
- `DEF_ALARM`, 10: reset value of the siren-hold time.
- `clock` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous reset, active-low.
- `ignition`, `door_driver`, `door_pass` in 1 each: level inputs, 1 = on/open. They are already synchronized and debounced upstream.
- `reprogram` in 1: one-cycle write strobe.
- `time_param_sel` in 2: parameter select (0 = arm, 1 = driver, 2 = pass, 3 = alarm).
- `time_value` in 4: value to write.
- `expired` in 1: timer done pulse.
- `one_hz_enable`, `half_hz_enable` in 1 each: blink levels from the timer.
- `start_timer` out 1: timer start request.
- `value` out 4: interval in seconds.
- `siren` out 1: siren drive.
- `status` out 1: status LED.
- `state_display` out 3: current state code.

## Operation
- **Parameter table:** four 4-bit registers, loaded from the `DEF_*` parameters on reset.
  - `reprogram` writes `time_value` into the register selected by `time_param_sel`.
  - A write also forces the FSM to ARMED and cancels any pending start.
  - A value of 0 is stored as written.
- **Start request:** `start_timer` is always asserted for exactly 2 consecutive cycles, called the start window. This guarantees the timer accepts it from IDLE, OPERATE or DONE.
  - `value` is registered at the first window cycle and held until the next start.
  - `expired` is ignored during the window and in any state that does not wait on the timer.
- **States and codes** (reset enters ARMED):
  - ARMED (0): ignition=1 → DISARMED. Else a door open → TRIGGERED. Start uses the driver delay if `door_driver` is open, otherwise the passenger delay; the driver delay wins if both are open.
  - TRIGGERED (1): ignition=1 → DISARMED. Else `expired` → ALARM.
  - ALARM (2): ignition=1 → DISARMED. Else all doors closed → ALARM_HOLD, starting the timer with the alarm parameter.
  - ALARM_HOLD (3): ignition=1 → DISARMED. Else a door opens → ALARM. Else `expired` → ARMED.
  - DISARMED (4): ignition=0 → WAIT_OPEN.
  - WAIT_OPEN (5): ignition=1 → DISARMED. Else `door_driver`=1 → WAIT_CLOSE.
  - WAIT_CLOSE (6): ignition=1 → DISARMED. Else both doors closed → ARMING, starting the timer with the arm parameter.
  - ARMING (7): ignition=1 → DISARMED. Else a door opens → WAIT_CLOSE. Else `expired` → ARMED.
- **Priority:** reset > `reprogram` > ignition > door events > `expired`.
- **Outputs:** all registered.
  - `siren` = 1 in ALARM and ALARM_HOLD.
  - `status` = `one_hz_enable` in ARMED, 1 in states 1–3, 0 in states 4–7.
  - `state_display` = state code.

## Timing
- **Reset values:**
  - `start_timer` = 0, `value` = 0, `siren` = 0, `status` = 0, `state_display` = 0.
  - Parameters at their defaults.
- **Latency:** an input event at edge N changes the state and raises `start_timer` at edge N+1.
- A start window ends 2 cycles later. The earliest honoured `expired` comes 3 cycles after the window ends, for a programmed value of 0.
- A new start request during an open window restarts the window with the new `value`.
- `reset` asserted mid-window drops `start_timer` immediately.
- A stale `expired` in the same cycle as the first window cycle is masked. The second window cycle restarts the timer from IDLE.

## Configuration
- **`ALARM_FUEL_PUMP_EN` defined:** adds inputs `hidden_sw` and `brake` and output `fuel_pump`.
  - `fuel_pump` latches to 1 when `ignition`, `hidden_sw` and `brake` are all 1 in the same cycle.
  - It clears when `ignition` goes 0 or on reset.
- **Undefined:** these ports and the latch are absent.

## Test plan
- **Driver entry:** start ARMED, set `door_driver`=1 → `start_timer` high 2 cycles with `value`=8. After timer expiry, state 2 and `siren`=1.
- **Door close:** in ALARM, close all doors → state 3 and start with `value`=10. Reopen a door before expiry → state 2, `siren` stays 1.
- **Arming:** set ignition=1 then 0, open and close the driver door → start with `value`=6. `expired` → state 0, `status` follows `one_hz_enable`.
- **Reprogram:** write sel=2, value=3 in DISARMED → state 0. Then open the passenger door → `value`=3.
- **Stale expiry:** inject `expired` in the first window cycle → ignored, `start_timer` still held for the second cycle. The next `expired` after the window is honoured.
- **Reset:** drop `reset` mid-alarm → all outputs 0 asynchronously and state 0. With `ALARM_FUEL_PUMP_EN`, set ignition, `hidden_sw` and `brake` for 1 cycle → `fuel_pump`=1 until ignition=0.
